shift_arbiter: RTL and testbench

Shares the single combinational 32-bit Shifter in the ALU between two requesters, using a valid/ready handshake on each request port and on the response port. Round-robin arbitration selects one requester per operation. The block registers the selected operands onto the Shifter inputs, captures the result one cycle later, and holds the tagged result until it is consumed. It also keeps a wrapping count of completed operations.

---
 rtl/shift_arbiter.sv | 126 ++++++++++++
 tb/tb_shift_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit shifter between two requesters.
// Latency: response valid two cycles after the accept cycle; one operation in flight.
// Backpressure: result held until resp_ready; no request is accepted until it is consumed.
module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_ctl0,
    input  logic             req0_ctl1,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_ctl0,
    input  logic             req1_ctl1,

    output logic [31:0]      sh_a,
    output logic [31:0]      sh_b,
    output logic             sh_ctl0,
    output logic             sh_ctl1,
    input  logic [31:0]      sh_out,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_out,
    output logic             resp_id,

    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ctl0;
        logic        ctl1;
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   grant_vld;
    logic   accept;
    op_t    op0;
    op_t    op1;
    op_t    sel_op;
    op_t    sh_op;

    assign op0 = '{a: req0_a, b: req0_b, ctl0: req0_ctl0, ctl1: req0_ctl1};
    assign op1 = '{a: req1_a, b: req1_b, ctl0: req1_ctl0, ctl1: req1_ctl1};

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign sel_op     = grant ? op1 : op0;
    assign accept     = (state == IDLE) && grant_vld;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sh_op      <= '0;
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_id    <= 1'b0;
            ops_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        sh_op      <= sel_op;
                        resp_id    <= grant;
                        last_grant <= grant;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    resp_out   <= sh_out;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_count  <= ops_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand registers only change on an accept, so the shifter inputs never glitch.
    assign sh_a    = sh_op.a;
    assign sh_b    = sh_op.b;
    assign sh_ctl0 = sh_op.ctl0;
    assign sh_ctl1 = sh_op.ctl1;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_shift_arbiter;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req0_ready;
    logic [31:0]      req0_a = '0, req0_b = '0;
    logic             req0_ctl0 = 1'b0, req0_ctl1 = 1'b0;
    logic             req1_valid = 1'b0, req1_ready;
    logic [31:0]      req1_a = '0, req1_b = '0;
    logic             req1_ctl0 = 1'b0, req1_ctl1 = 1'b0;
    logic [31:0]      sh_a, sh_b, sh_out;
    logic             sh_ctl0, sh_ctl1;
    logic             resp_valid, resp_id, busy;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_out;
    logic [CNT_W-1:0] ops_count;

    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   exp_count = 0;
    logic exp_last = 1'b1;

    shift_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctl0(req0_ctl0), .req0_ctl1(req0_ctl1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctl0(req1_ctl0), .req1_ctl1(req1_ctl1),
        .sh_a(sh_a), .sh_b(sh_b), .sh_ctl0(sh_ctl0), .sh_ctl1(sh_ctl1), .sh_out(sh_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out), .resp_id(resp_id),
        .busy(busy), .ops_count(ops_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic c0, input logic c1);
        logic [4:0]  n = b[4:0];
        logic signed [31:0] sa = a;
        if (!c1) return a << n;
        if (c0) return a >> n;
        return sa >>> n;
    endfunction

    // External shifter model driven by the registered operands.
    assign sh_out = ref_shift(sh_a, sh_b, sh_ctl0, sh_ctl1);

    // Round-robin rule: a lone requester wins; on a tie the one that did not win last time.
    function automatic logic exp_grant(input logic v0, input logic v1);
        if (v0 && v1) return !exp_last;
        return v1;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        next();
        next();
        rst = 1'b0;
        exp_count = 0;
        exp_last = 1'b1;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic c1);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctl0 = c0; req0_ctl1 = c1;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic c1);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctl0 = c0; req1_ctl1 = c1;
    endtask

    task automatic wait_ready(output logic got, output logic id);
        got = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mid();
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                id = req1_ready;
                return;
            end
            next();
        end
    endtask

    task automatic test_reset();
        do_reset();
        mid();
        total++; if ({resp_valid, resp_out, resp_id} !== 34'd0) $display("FAIL reset_resp got=%b/%h/%b exp=0/0/0", resp_valid, resp_out, resp_id); else passed++;
        total++; if ({sh_a, sh_b, sh_ctl0, sh_ctl1} !== 66'd0) $display("FAIL reset_sh got=%h/%h/%b%b exp=0", sh_a, sh_b, sh_ctl0, sh_ctl1); else passed++;
        total++; if ({busy, ops_count, req0_ready, req1_ready} !== '0) $display("FAIL reset_misc got busy=%b cnt=%0d rdy=%b%b exp=0", busy, ops_count, req0_ready, req1_ready); else passed++;
    endtask

    task automatic test_single();
        logic got, id;
        do_reset();
        resp_ready = 1'b1;
        drive0(32'h0000_00F0, 32'd4, 1'b1, 1'b1);
        wait_ready(got, id);
        total++; if (!got || id !== 1'b0 || req1_ready !== 1'b0) $display("FAIL single_grant got=%b id=%b rdy1=%b exp=1/0/0", got, id, req1_ready); else passed++;
        exp_last = 1'b0;
        next();
        req0_valid = 1'b0;
        mid();
        total++; if ({sh_a, sh_b, sh_ctl0, sh_ctl1} !== {32'hF0, 32'd4, 2'b11}) $display("FAIL single_sh got=%h/%h/%b%b exp=f0/4/11", sh_a, sh_b, sh_ctl0, sh_ctl1); else passed++;
        total++; if (resp_valid !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0) $display("FAIL single_issue got vld=%b busy=%b rdy0=%b exp=0/1/0", resp_valid, busy, req0_ready); else passed++;
        next();
        mid();
        total++; if (resp_valid !== 1'b1 || resp_out !== 32'h0000_000F || resp_id !== 1'b0) $display("FAIL single_resp got=%b/%h/%b exp=1/0000000f/0", resp_valid, resp_out, resp_id); else passed++;
        next();
        mid();
        exp_count++;
        total++; if (resp_valid !== 1'b0 || ops_count !== CNT_W'(1) || busy !== 1'b0) $display("FAIL single_done got vld=%b cnt=%0d busy=%b exp=0/1/0", resp_valid, ops_count, busy); else passed++;
        next();
    endtask

    task automatic test_arith();
        logic got, id;
        resp_ready = 1'b1;
        drive1(32'h8000_0000, 32'd4, 1'b0, 1'b1);
        wait_ready(got, id);
        total++; if (!got || id !== exp_grant(1'b0, 1'b1)) $display("FAIL arith_grant got=%b id=%b exp=1/1", got, id); else passed++;
        exp_last = 1'b1;
        next(); req1_valid = 1'b0; next(); mid();
        total++; if (resp_out !== 32'hF800_0000 || resp_id !== 1'b1) $display("FAIL arith_sra got=%h/%b exp=f8000000/1", resp_out, resp_id); else passed++;
        next();
        exp_count++;
        drive0(32'h0000_0001, 32'd31, 1'b0, 1'b0);
        wait_ready(got, id);
        total++; if (!got || id !== 1'b0) $display("FAIL arith_grant0 got=%b id=%b exp=1/0", got, id); else passed++;
        exp_last = 1'b0;
        next(); req0_valid = 1'b0; next(); mid();
        total++; if (resp_out !== 32'h8000_0000 || resp_id !== 1'b0) $display("FAIL arith_sll got=%h/%b exp=80000000/0", resp_out, resp_id); else passed++;
        next(); mid();
        exp_count++;
        total++; if (ops_count !== CNT_W'(exp_count)) $display("FAIL arith_count got=%0d exp=%0d", ops_count, exp_count % 4); else passed++;
        next();
    endtask

    task automatic test_rr();
        logic got, id, e;
        int   prev;
        do_reset();
        resp_ready = 1'b1;
        drive0(32'h0000_00F0, 32'd4, 1'b1, 1'b1);
        drive1(32'h0000_0001, 32'd8, 1'b1, 1'b0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(got, id);
            e = exp_grant(1'b1, 1'b1);
            total++; if (!got || id !== e || (req0_ready && req1_ready)) $display("FAIL rr_grant%0d got=%b id=%b exp=1/%b", k, got, id, e); else passed++;
            if (k > 0) begin
                total++; if (cyc - prev !== 3) $display("FAIL rr_interval%0d got=%0d exp=3", k, cyc - prev); else passed++;
            end
            prev = cyc;
            exp_last = e;
            next(); next(); mid();
            total++; if (resp_valid !== 1'b1 || resp_id !== e || resp_out !== (e ? 32'h100 : 32'hF)) $display("FAIL rr_resp%0d got=%b/%b/%h exp=1/%b/%h", k, resp_valid, resp_id, resp_out, e, e ? 32'h100 : 32'hF); else passed++;
            next();
            exp_count++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic got, id;
        logic [CNT_W-1:0] cnt0;
        resp_ready = 1'b0;
        drive0(32'h1234_5678, 32'd8, 1'b1, 1'b1);
        wait_ready(got, id);
        total++; if (!got || id !== exp_grant(1'b1, 1'b0)) $display("FAIL bp_grant got=%b id=%b exp=1/0", got, id); else passed++;
        exp_last = 1'b0;
        cnt0 = CNT_W'(exp_count);
        next(); req0_valid = 1'b0; next(); mid();
        total++; if (resp_valid !== 1'b1 || resp_out !== 32'h0012_3456) $display("FAIL bp_first got=%b/%h exp=1/00123456", resp_valid, resp_out); else passed++;
        for (int i = 0; i < 5; i++) begin
            next();
            if (i == 0) begin
                req0_valid = 1'b1;
                drive1(32'hFFFF_0000, 32'd1, 1'b1, 1'b1);
            end
            mid();
            total++; if (resp_valid !== 1'b1 || resp_out !== 32'h0012_3456 || resp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || ops_count !== cnt0)
                $display("FAIL bp_hold%0d got=%b/%h/%b rdy=%b%b cnt=%0d exp=1/00123456/0 rdy=00 cnt=%0d", i, resp_valid, resp_out, resp_id, req0_ready, req1_ready, ops_count, cnt0); else passed++;
        end
        next();
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mid();
        total++; if (resp_valid !== 1'b1) $display("FAIL bp_last got=%b exp=1", resp_valid); else passed++;
        next(); mid();
        exp_count++;
        total++; if (resp_valid !== 1'b0 || ops_count !== CNT_W'(exp_count)) $display("FAIL bp_done got=%b cnt=%0d exp=0/%0d", resp_valid, ops_count, exp_count % 4); else passed++;
        next();
    endtask

    task automatic test_reset_mid();
        logic got, id;
        for (int ph = 0; ph < 2; ph++) begin
            resp_ready = (ph == 0);
            drive0(32'hAAAA_0000, 32'd4, 1'b1, 1'b1);
            wait_ready(got, id);
            next();
            req0_valid = 1'b0;
            if (ph == 1) next();
            rst = 1'b1;
            next();
            rst = 1'b0;
            exp_count = 0;
            exp_last = 1'b1;
            mid();
            total++; if ({resp_valid, resp_out, resp_id, sh_a, sh_b, sh_ctl0, sh_ctl1} !== 100'd0) $display("FAIL rstmid%0d_out got=%b/%h/%b sh=%h/%h exp=0", ph, resp_valid, resp_out, resp_id, sh_a, sh_b); else passed++;
            total++; if (busy !== 1'b0 || ops_count !== '0) $display("FAIL rstmid%0d_state got busy=%b cnt=%0d exp=0/0", ph, busy, ops_count); else passed++;
            next(); mid();
            total++; if (resp_valid !== 1'b0) $display("FAIL rstmid%0d_noresp got=%b exp=0", ph, resp_valid); else passed++;
            next();
            resp_ready = 1'b1;
            drive0(32'h0000_00F0, 32'd4, 1'b1, 1'b1);
            drive1(32'h0000_0001, 32'd8, 1'b1, 1'b0);
            wait_ready(got, id);
            total++; if (!got || id !== exp_grant(1'b1, 1'b1)) $display("FAIL rstmid%0d_tie got=%b id=%b exp=1/0", ph, got, id); else passed++;
            exp_last = 1'b0;
            next();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            next(); next(); next();
            exp_count++;
        end
    endtask

    task automatic test_wrap();
        logic got, id;
        logic [31:0] a;
        logic [CNT_W-1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = $urandom;
            drive0(a, 32'd32, 1'b1, 1'b1);
            wait_ready(got, id);
            next();
            req0_valid = 1'b0;
            mid();
            total++; if (sh_b !== 32'h0000_0020) $display("FAIL wrap_shb%0d got=%h exp=00000020", k, sh_b); else passed++;
            next(); mid();
            total++; if (resp_out !== a) $display("FAIL wrap_b32_%0d got=%h exp=%h", k, resp_out, a); else passed++;
            next(); mid();
            total++; if (ops_count !== wrap_seq[k]) $display("FAIL wrap_cnt%0d got=%0d exp=%0d", k, ops_count, wrap_seq[k]); else passed++;
            next();
        end
        exp_count = 5;
        exp_last = 1'b0;
    endtask

    task automatic test_random();
        logic got, id, e, v0, v1;
        logic [1:0] rv;
        logic [31:0] a0, b0, a1, b1, ea, eb, er;
        logic c00, c01, c10, c11, ec0, ec1;
        int stall;
        for (int it = 0; it < 40; it++) begin
            rv = 2'($urandom_range(1, 3));
            v0 = rv[0]; v1 = rv[1];
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            {c00, c01, c10, c11} = 4'($urandom);
            stall = $urandom_range(0, 3);
            resp_ready = (stall == 0);
            if (v0) drive0(a0, b0, c00, c01);
            if (v1) drive1(a1, b1, c10, c11);
            e = exp_grant(v0, v1);
            {ea, eb, ec0, ec1} = e ? {a1, b1, c10, c11} : {a0, b0, c00, c01};
            er = ref_shift(ea, eb, ec0, ec1);
            wait_ready(got, id);
            total++; if (!got || id !== e || (req0_ready && req1_ready)) $display("FAIL rnd%0d_grant got=%b id=%b exp=1/%b", it, got, id, e); else passed++;
            exp_last = e;
            next();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            mid();
            total++; if ({sh_a, sh_b, sh_ctl0, sh_ctl1} !== {ea, eb, ec0, ec1}) $display("FAIL rnd%0d_sh got=%h/%h/%b%b exp=%h/%h/%b%b", it, sh_a, sh_b, sh_ctl0, sh_ctl1, ea, eb, ec0, ec1); else passed++;
            next(); mid();
            total++; if (resp_valid !== 1'b1 || resp_out !== er || resp_id !== e) $display("FAIL rnd%0d_resp got=%b/%h/%b exp=1/%h/%b", it, resp_valid, resp_out, resp_id, er, e); else passed++;
            for (int s = 0; s < stall; s++) begin
                next();
                if (s == stall - 1) resp_ready = 1'b1;
                mid();
                total++; if (resp_valid !== 1'b1 || resp_out !== er) $display("FAIL rnd%0d_hold%0d got=%b/%h exp=1/%h", it, s, resp_valid, resp_out, er); else passed++;
            end
            next(); mid();
            exp_count++;
            total++; if (resp_valid !== 1'b0 || ops_count !== CNT_W'(exp_count)) $display("FAIL rnd%0d_done got=%b cnt=%0d exp=0/%0d", it, resp_valid, ops_count, exp_count % 4); else passed++;
            next();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_rr();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
